ahb_output_arbiter_rr: RTL and testbench



---
 rtl/ahb_matrix_pkg.sv | 47 ++++
 rtl/ahb_output_arbiter_rr_if.sv | 36 +++
 rtl/ahb_burst_hold_tracker.sv | 114 +++++++++++
 rtl/ahb_output_arbiter_rr.sv | 126 ++++++++++++
 tb/tb_ahb_output_arbiter_rr.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_matrix_pkg
//  Purpose  : Shared AHB bus-matrix definitions: HTRANS/HBURST encodings,
//             arbitration mode constants and a fixed-burst length helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ahb_matrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Beats still to come after the NONSEQ beat of a fixed-length burst,
    // minus one: the hold is released on the SEQ that sees remain==0, which
    // is the last beat of the burst.
    function automatic logic [3:0] fixed_burst_remain(input hburst_t burst);
        logic [3:0] remain;
        case (burst)
            HBURST_WRAP16, HBURST_INCR16: remain = 4'd14;
            HBURST_WRAP8,  HBURST_INCR8:  remain = 4'd6;
            HBURST_WRAP4,  HBURST_INCR4:  remain = 4'd2;
            default:                      remain = 4'd0;
        endcase
        return remain;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_output_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_output_arbiter_rr_if
//  Purpose  : Request/grant and output-transfer signals of one bus-matrix
//             output stage.
//  Ports    : master modport - drives requests and output transfer info,
//                              observes the grant
//             slave  modport - the arbiter side
//  Revision : 1.0  initial release
// ============================================================================
interface ahb_output_arbiter_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 3
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] port_en;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic [NUM_PORTS-1:0] grant;
    logic                 no_port;

    modport master (
        output req, port_en, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, grant, no_port
    );

    modport slave (
        input  req, port_en, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, grant, no_port
    );
endinterface
`default_nettype wire

// File: rtl/ahb_burst_hold_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_burst_hold_tracker
//  Purpose  : Tracks the remaining beats of the current output burst and
//             whether arbitration must be held. Undefined-length INCR bursts
//             are held for INCR_HOLD_BEATS; after EARLY_INCR_LIMIT
//             consecutive early-terminated held INCRs they are not held.
//  Ports    : HCLK, HRESETn        clock, async active-low reset
//             HREADYM              qualifies every register update
//             HSELM/HTRANSM/HBURSTM current output transfer
//             next_hold            combinational hold for the next cycle
//             hold                 registered hold
//  Revision : 1.0  initial release
// ============================================================================
module ahb_burst_hold_tracker
    import ahb_matrix_pkg::*;
#(
    parameter int INCR_HOLD_BEATS  = 4,
    parameter int EARLY_INCR_LIMIT = 1
) (
    input  wire logic       HCLK,
    input  wire logic       HRESETn,
    input  wire logic       HREADYM,
    input  wire logic       HSELM,
    input  wire logic [1:0] HTRANSM,
    input  wire logic [2:0] HBURSTM,
    output logic            next_hold,
    output logic            hold
);
    localparam logic [3:0] INCR_REMAIN = 4'(INCR_HOLD_BEATS - 2);
    localparam logic [1:0] EARLY_LIMIT = 2'(EARLY_INCR_LIMIT);

    logic [3:0] remain;
    logic [3:0] next_remain;
    logic [1:0] early_cnt;
    logic [1:0] next_early_cnt;
    htrans_t    trans;
    hburst_t    burst;

    assign trans = htrans_t'(HTRANSM);
    assign burst = hburst_t'(HBURSTM);

    always_comb begin
        next_remain = remain;
        next_hold   = hold;
        if (!HSELM) begin
            next_remain = 4'd0;
            next_hold   = 1'b0;
        end else begin
            case (trans)
                HTRANS_NONSEQ: begin
                    if (burst == HBURST_SINGLE) begin
                        next_remain = 4'd0;
                        next_hold   = 1'b0;
                    end else if (burst == HBURST_INCR) begin
                        if (early_cnt == EARLY_LIMIT) begin
                            next_remain = 4'd0;
                            next_hold   = 1'b0;
                        end else begin
                            next_remain = INCR_REMAIN;
                            next_hold   = 1'b1;
                        end
                    end else begin
                        next_remain = fixed_burst_remain(burst);
                        next_hold   = 1'b1;
                    end
                end
                HTRANS_SEQ: begin
                    if (remain == 4'd0) begin
                        next_remain = 4'd0;
                        next_hold   = 1'b0;
                    end else begin
                        next_remain = remain - 4'd1;
                    end
                end
                HTRANS_BUSY: begin
                    next_remain = remain;
                    next_hold   = hold;
                end
                default: begin
                    next_remain = 4'd0;
                    next_hold   = 1'b0;
                end
            endcase
        end
    end

    // A NONSEQ arriving while still held means the previous burst ended
    // before its hold window expired.
    always_comb begin
        next_early_cnt = early_cnt;
        if (!next_hold) begin
            next_early_cnt = 2'd0;
        end else if (hold && (trans == HTRANS_NONSEQ)) begin
            if (early_cnt != EARLY_LIMIT) begin
                next_early_cnt = early_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain    <= 4'd0;
            hold      <= 1'b0;
            early_cnt <= 2'd0;
        end else if (HREADYM) begin
            remain    <= next_remain;
            hold      <= next_hold;
            early_cnt <= next_early_cnt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_output_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_output_arbiter_rr
//  Purpose  : Output-stage arbiter of the AHB bus matrix. Selects which input
//             stage drives the shared slave, holding the grant across locked
//             sequences and bursts. Round-robin or fixed priority, with a
//             runtime per-port enable mask.
//  Ports    : HCLK, HRESETn  clock, async active-low reset
//             bus (slave)    req, port_en, HREADYM, HSELM, HTRANSM, HBURSTM,
//                            HMASTLOCKM in; addr_in_port, grant, no_port out
//  Revision : 1.0  initial release
// ============================================================================
module ahb_output_arbiter_rr
    import ahb_matrix_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int PORT_W           = 3,
    parameter int ARB_MODE         = 0,
    parameter int INCR_HOLD_BEATS  = 4,
    parameter int EARLY_INCR_LIMIT = 1
) (
    input  wire logic              HCLK,
    input  wire logic              HRESETn,
    ahb_output_arbiter_rr_if.slave bus
);
    logic                 next_hold;
    logic                 tracker_hold_unused;
    logic [NUM_PORTS-1:0] elig;
    logic                 found;
    logic [PORT_W-1:0]    cand;
    logic                 cur_en;
    logic [PORT_W-1:0]    next_addr;
    logic                 next_no_port;
    logic [NUM_PORTS-1:0] next_grant;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic [NUM_PORTS-1:0] grant;

    ahb_burst_hold_tracker #(
        .INCR_HOLD_BEATS  (INCR_HOLD_BEATS),
        .EARLY_INCR_LIMIT (EARLY_INCR_LIMIT)
    ) u_tracker (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HREADYM   (bus.HREADYM),
        .HSELM     (bus.HSELM),
        .HTRANSM   (bus.HTRANSM),
        .HBURSTM   (bus.HBURSTM),
        .next_hold (next_hold),
        .hold      (tracker_hold_unused)
    );

    assign elig = bus.req & bus.port_en;

    // Candidate search. Round-robin starts one past the last grant and ends
    // on the last grant itself; addr_in_port keeps its value while no_port
    // is set, so fairness survives idle gaps.
    always_comb begin
        found  = 1'b0;
        cand   = addr_in_port;
        cur_en = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (PORT_W'(j) == addr_in_port) begin
                cur_en = bus.port_en[j];
            end
        end
        if (ARB_MODE == ARB_FIXED) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && elig[j]) begin
                    found = 1'b1;
                    cand  = PORT_W'(j);
                end
            end
        end else begin
            for (int s = 1; s <= NUM_PORTS; s++) begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (!found && elig[j] &&
                        (((int'(addr_in_port) + s) % NUM_PORTS) == j)) begin
                        found = 1'b1;
                        cand  = PORT_W'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        next_addr    = addr_in_port;
        next_no_port = no_port;
        if (bus.HMASTLOCKM || next_hold) begin
            next_addr    = addr_in_port;
            next_no_port = no_port;
        end else if (found) begin
            next_addr    = cand;
            next_no_port = 1'b0;
        end else if (!no_port && bus.HSELM && cur_en) begin
            // IDLE park: nobody else wants the slave, keep the current owner
            next_addr    = addr_in_port;
            next_no_port = 1'b0;
        end else begin
            next_addr    = addr_in_port;
            next_no_port = 1'b1;
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            next_grant[j] = !next_no_port && (next_addr == PORT_W'(j));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            grant        <= '0;
        end else if (bus.HREADYM) begin
            addr_in_port <= next_addr;
            no_port      <= next_no_port;
            grant        <= next_grant;
        end
    end

    assign bus.addr_in_port = addr_in_port;
    assign bus.no_port      = no_port;
    assign bus.grant        = grant;

endmodule
`default_nettype wire

// File: tb/tb_ahb_output_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_output_arbiter_rr
//  Purpose  : Directed, table-driven bench for ahb_output_arbiter_rr with a
//             round-robin instance and a fixed-priority instance sharing
//             the same stimulus.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_output_arbiter_rr;
    import ahb_matrix_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_output_arbiter_rr_if #(.NUM_PORTS(4), .PORT_W(3)) bus ();
    ahb_output_arbiter_rr_if #(.NUM_PORTS(4), .PORT_W(3)) bus_fx ();

    assign bus_fx.req        = bus.req;
    assign bus_fx.port_en    = bus.port_en;
    assign bus_fx.HREADYM    = bus.HREADYM;
    assign bus_fx.HSELM      = bus.HSELM;
    assign bus_fx.HTRANSM    = bus.HTRANSM;
    assign bus_fx.HBURSTM    = bus.HBURSTM;
    assign bus_fx.HMASTLOCKM = bus.HMASTLOCKM;

    ahb_output_arbiter_rr #(
        .NUM_PORTS(4), .PORT_W(3), .ARB_MODE(ARB_RR),
        .INCR_HOLD_BEATS(4), .EARLY_INCR_LIMIT(1)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    ahb_output_arbiter_rr #(
        .NUM_PORTS(4), .PORT_W(3), .ARB_MODE(ARB_FIXED),
        .INCR_HOLD_BEATS(4), .EARLY_INCR_LIMIT(1)
    ) dut_fx (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_fx)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] en;
        logic       rdy;
        logic       sel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic [2:0] exp_addr;
        logic       exp_np;
        logic [3:0] exp_grant;
        logic       chk_fx;
        logic [3:0] fx_grant;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] en,
                                input logic rdy, input logic sel,
                                input logic [1:0] trans, input logic [2:0] burst,
                                input logic lock, input logic [2:0] exp_addr,
                                input logic exp_np, input logic [3:0] exp_grant,
                                input logic chk_fx, input logic [3:0] fx_grant);
        vec_t v;
        v.req = req;           v.en = en;           v.rdy = rdy;
        v.sel = sel;           v.trans = trans;     v.burst = burst;
        v.lock = lock;         v.exp_addr = exp_addr;
        v.exp_np = exp_np;     v.exp_grant = exp_grant;
        v.chk_fx = chk_fx;     v.fx_grant = fx_grant;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req        = v.req;
        bus.port_en    = v.en;
        bus.HREADYM    = v.rdy;
        bus.HSELM      = v.sel;
        bus.HTRANSM    = v.trans;
        bus.HBURSTM    = v.burst;
        bus.HMASTLOCKM = v.lock;
    endtask

    task automatic check_rr(input string tag, input logic [2:0] a,
                            input logic np, input logic [3:0] g);
        check({tag, "_addr"},    {5'd0, bus.addr_in_port}, {5'd0, a});
        check({tag, "_no_port"}, {7'd0, bus.no_port},      {7'd0, np});
        check({tag, "_grant"},   {4'd0, bus.grant},        {4'd0, g});
    endtask

    task automatic step_vec(input vec_t v, input string tag);
        drive(v);
        @(posedge HCLK);
        #1;
        check_rr(tag, v.exp_addr, v.exp_np, v.exp_grant);
        if (v.chk_fx) begin
            check({tag, "_fx_grant"}, {4'd0, bus_fx.grant}, {4'd0, v.fx_grant});
        end
    endtask

    localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I8 = 3'b101, I16 = 3'b111;

    initial begin
        // ---- table ----------------------------------------------------------
        // first arbitration after reset
        vecs.push_back(mk(4'b0110, 4'b1111, 1, 1, N, SGL, 0, 3'd1, 0, 4'b0010, 1, 4'b0010));
        // round-robin rotation; fixed priority stays on port 0
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, N, SGL, 0, 3'd2, 0, 4'b0100, 1, 4'b0001));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, N, SGL, 0, 3'd3, 0, 4'b1000, 1, 4'b0001));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, N, SGL, 0, 3'd0, 0, 4'b0001, 1, 4'b0001));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, N, SGL, 0, 3'd1, 0, 4'b0010, 1, 4'b0001));
        // move to port 2, then INCR8 with BUSY and a stall
        vecs.push_back(mk(4'b0100, 4'b1111, 1, 1, I, SGL, 0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, N, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, B, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd2, 0, 4'b0100, 0, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b1111, 1, 1, S, I8,  0, 3'd3, 0, 4'b1000, 0, 4'b0000));
        // early-terminated INCR bursts from port 1
        vecs.push_back(mk(4'b0010, 4'b1111, 1, 1, I, SGL, 0, 3'd1, 0, 4'b0010, 0, 4'b0000));
        vecs.push_back(mk(4'b0011, 4'b1111, 1, 1, N, INC, 0, 3'd1, 0, 4'b0010, 0, 4'b0000));
        vecs.push_back(mk(4'b0011, 4'b1111, 1, 1, S, INC, 0, 3'd1, 0, 4'b0010, 0, 4'b0000));
        vecs.push_back(mk(4'b0011, 4'b1111, 1, 1, N, INC, 0, 3'd1, 0, 4'b0010, 0, 4'b0000));
        vecs.push_back(mk(4'b0011, 4'b1111, 1, 1, S, INC, 0, 3'd1, 0, 4'b0010, 0, 4'b0000));
        vecs.push_back(mk(4'b0011, 4'b1111, 1, 1, N, INC, 0, 3'd0, 0, 4'b0001, 0, 4'b0000));
        // locked sequence on port 3 with its request dropped
        vecs.push_back(mk(4'b1000, 4'b1111, 1, 1, I, SGL, 0, 3'd3, 0, 4'b1000, 0, 4'b0000));
        vecs.push_back(mk(4'b0111, 4'b1111, 1, 1, N, SGL, 1, 3'd3, 0, 4'b1000, 0, 4'b0000));
        vecs.push_back(mk(4'b0111, 4'b1111, 1, 1, I, SGL, 1, 3'd3, 0, 4'b1000, 0, 4'b0000));
        vecs.push_back(mk(4'b0111, 4'b1111, 1, 1, I, SGL, 0, 3'd0, 0, 4'b0001, 0, 4'b0000));
        // masked port 2 never granted
        vecs.push_back(mk(4'b0100, 4'b1011, 1, 0, I, SGL, 0, 3'd0, 1, 4'b0000, 0, 4'b0000));
        vecs.push_back(mk(4'b0100, 4'b1011, 1, 1, I, SGL, 0, 3'd0, 1, 4'b0000, 0, 4'b0000));
        // IDLE park, then the parked port loses its enable
        vecs.push_back(mk(4'b0001, 4'b1011, 1, 1, I, SGL, 0, 3'd0, 0, 4'b0001, 0, 4'b0000));
        vecs.push_back(mk(4'b0000, 4'b1011, 1, 1, I, SGL, 0, 3'd0, 0, 4'b0001, 0, 4'b0000));
        vecs.push_back(mk(4'b0000, 4'b1010, 1, 1, I, SGL, 0, 3'd0, 1, 4'b0000, 0, 4'b0000));

        // ---- reset --------------------------------------------------------
        drive(mk(4'b0000, 4'b1111, 1, 0, I, SGL, 0, 3'd0, 1, 4'b0000, 0, 4'b0000));
        repeat (2) @(posedge HCLK);
        #1;
        check_rr("reset", 3'd0, 1'b1, 4'b0000);
        check("reset_fx_no_port", {7'd0, bus_fx.no_port}, 8'd1);
        check("reset_fx_grant",   {4'd0, bus_fx.grant},   8'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- asynchronous reset in the middle of an INCR16 ----------------
        step_vec(mk(4'b0100, 4'b1111, 1, 1, I, SGL, 0, 3'd2, 0, 4'b0100, 0, 4'b0000), "r16_arb");
        step_vec(mk(4'b1111, 4'b1111, 1, 1, N, I16, 0, 3'd2, 0, 4'b0100, 0, 4'b0000), "r16_b1");
        for (int k = 2; k <= 5; k++) begin
            step_vec(mk(4'b1111, 4'b1111, 1, 1, S, I16, 0, 3'd2, 0, 4'b0100, 0, 4'b0000),
                     $sformatf("r16_b%0d", k));
        end
        #2;
        HRESETn = 1'b0;
        #1;
        check_rr("async_rst", 3'd0, 1'b1, 4'b0000);
        check("async_rst_fx_no_port", {7'd0, bus_fx.no_port}, 8'd1);
        @(posedge HCLK);
        #1;
        drive(mk(4'b0010, 4'b1111, 1, 1, N, SGL, 0, 3'd0, 0, 4'b0000, 0, 4'b0000));
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_rr("post_rst", 3'd1, 1'b0, 4'b0010);
        // a SEQ right after reset must find no residual burst count
        step_vec(mk(4'b0100, 4'b1111, 1, 1, S, I16, 0, 3'd2, 0, 4'b0100, 0, 4'b0000), "post_rst_seq");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
